// File: rtl/v_regfile_mp_pkg.sv
// Shared definitions for the multi-port vector register file: defaults, the
// clear-engine state encoding and the element-granular merge.
package v_pkg;

  localparam int VLEN_DEF  = 512;
  localparam int ELEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  // Container width for elem_merge; register widths up to this are supported.
  localparam int VLEN_MAX  = 1024;
  localparam int IDXW      = $clog2(VLEN_MAX);

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  // Bit i takes new_v when the mask bit of its element (i / elen) is set.
  function automatic logic [VLEN_MAX-1:0] elem_merge(
    input logic [VLEN_MAX-1:0] old_v,
    input logic [VLEN_MAX-1:0] new_v,
    input logic [VLEN_MAX-1:0] mask,
    input int                  elen
  );
    logic [VLEN_MAX-1:0] res;
    logic [IDXW-1:0]     idx;
    res = old_v;
    for (int i = 0; i < VLEN_MAX; i++) begin
      idx = IDXW'(i / elen);
      if (mask[idx]) res[i] = new_v[i];
    end
    return res;
  endfunction

endpackage

// File: rtl/v_regfile_mp_if.sv
// Bus bundle for v_regfile_mp: clear control, one masked write port and NRD
// packed read ports.
interface v_regfile_mp_if import v_pkg::*; #(
  parameter  int VLEN  = VLEN_DEF,
  parameter  int ELEN  = ELEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(NREGS),
  localparam int NEL   = VLEN / ELEN
);

  // Timing contract (no backpressure): a write takes effect at the clock edge
  // where w_ena_i=1, busy_o=0 and clr_i=0, otherwise it is dropped; a read
  // sampled with r_ena_i[p]=1 returns r_valid_o[p]/r_data_o one edge later.
  logic                clr_i;
  logic                busy_o;
  logic                w_ena_i;
  logic [AW-1:0]       w_addr_i;
  logic [NEL-1:0]      w_mask_i;
  logic [VLEN-1:0]     w_data_i;
  logic [NRD-1:0]      r_ena_i;
  logic [NRD*AW-1:0]   r_addr_i;
  logic [NRD*VLEN-1:0] r_data_o;
  logic [NRD-1:0]      r_valid_o;
  state_e              dbg_state_o;

  modport master (
    output clr_i, w_ena_i, w_addr_i, w_mask_i, w_data_i, r_ena_i, r_addr_i,
    input  busy_o, r_data_o, r_valid_o, dbg_state_o
  );

  modport slave (
    input  clr_i, w_ena_i, w_addr_i, w_mask_i, w_data_i, r_ena_i, r_addr_i,
    output busy_o, r_data_o, r_valid_o, dbg_state_o
  );

endinterface

// File: rtl/v_regfile_mp_rdport.sv
// One registered read port: address mux, same-cycle write bypass, register-0
// forcing and the output flops.
module v_regfile_rdport import v_pkg::*; #(
  parameter  int VLEN     = VLEN_DEF,
  parameter  int ELEN     = ELEN_DEF,
  parameter  int NREGS    = NREGS_DEF,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(NREGS),
  localparam int NEL      = VLEN / ELEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rd_ok_i,
  input  logic            r_ena_i,
  input  logic [AW-1:0]   r_addr_i,
  input  logic [VLEN-1:0] regs_i [NREGS],
  input  logic            wr_acc_i,
  input  logic [AW-1:0]   w_addr_i,
  input  logic [NEL-1:0]  w_mask_i,
  input  logic [VLEN-1:0] w_data_i,
  output logic [VLEN-1:0] r_data_o,
  output logic            r_valid_o
);

  logic [VLEN-1:0] cur;
  logic [VLEN-1:0] data_d, data_q;
  logic            valid_d, valid_q;

  always_comb begin
    cur = regs_i[r_addr_i];
    // Bypass returns the post-write contents of the register being written.
    if (wr_acc_i && (w_addr_i == r_addr_i)) begin
      cur = VLEN'(elem_merge(VLEN_MAX'(cur), VLEN_MAX'(w_data_i),
                             VLEN_MAX'(w_mask_i), ELEN));
    end
    if ((ZERO_REG != 0) && (r_addr_i == '0)) cur = '0;
    valid_d = r_ena_i && rd_ok_i;
    data_d  = valid_d ? cur : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign r_data_o  = data_q;
  assign r_valid_o = valid_q;

endmodule

// File: rtl/v_regfile_mp.sv
// Parametrised vector register file: NRD registered read ports, one masked
// write port, storage zeroed by a sequential clear engine.
module v_regfile_mp import v_pkg::*; #(
  parameter  int VLEN     = VLEN_DEF,
  parameter  int ELEN     = ELEN_DEF,
  parameter  int NREGS    = NREGS_DEF,
  parameter  int NRD      = 2,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input logic           clk,
  input logic           rst_n,
  v_regfile_mp_if.slave bus
);

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
  logic            clr_we;
  logic            wr_acc;
  logic            rd_ok;
  logic [VLEN-1:0] wr_merged;
  logic [VLEN-1:0] regs_q [NREGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    wr_acc    = 1'b0;
    if (state_q == CLEAR) begin
      // Storage is only touched once reset is released.
      clr_we    = rst_n;
      clr_cnt_d = clr_cnt_q + AW'(1);
      if (clr_cnt_q == AW'(NREGS - 1)) state_d = IDLE;
    end else if (bus.clr_i) begin
      state_d   = CLEAR;
      clr_cnt_d = '0;
    end else begin
      wr_acc = rst_n && bus.w_ena_i &&
               !((ZERO_REG != 0) && (bus.w_addr_i == '0));
    end
  end

  assign wr_merged = VLEN'(elem_merge(VLEN_MAX'(regs_q[bus.w_addr_i]),
                                      VLEN_MAX'(bus.w_data_i),
                                      VLEN_MAX'(bus.w_mask_i), ELEN));

  always_ff @(posedge clk) begin
    if (clr_we) begin
      regs_q[clr_cnt_q] <= '0;
    end else if (wr_acc) begin
      regs_q[bus.w_addr_i] <= wr_merged;
    end
  end

  assign rd_ok           = (state_q == IDLE);
  assign bus.busy_o      = (state_q == CLEAR);
  assign bus.dbg_state_o = state_q;

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    v_regfile_rdport #(
      .VLEN(VLEN), .ELEN(ELEN), .NREGS(NREGS), .ZERO_REG(ZERO_REG)
    ) u_rd (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_ok_i   (rd_ok),
      .r_ena_i   (bus.r_ena_i[p]),
      .r_addr_i  (bus.r_addr_i[p*AW +: AW]),
      .regs_i    (regs_q),
      .wr_acc_i  (wr_acc),
      .w_addr_i  (bus.w_addr_i),
      .w_mask_i  (bus.w_mask_i),
      .w_data_i  (bus.w_data_i),
      .r_data_o  (bus.r_data_o[p*VLEN +: VLEN]),
      .r_valid_o (bus.r_valid_o[p])
    );
  end

endmodule

// File: tb/tb_v_regfile_mp.sv
// Bench for v_regfile_mp: default 32x512 2-port instance plus a 16x256 3-port
// instance, each checked against an element-level model of the file.
module tb_v_regfile_mp;

  logic clk = 1'b0;
  logic rst_a_n, rst_b_n;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  v_regfile_mp_if #(.VLEN(512), .ELEN(32), .NREGS(32), .NRD(2)) bus_a ();
  v_regfile_mp_if #(.VLEN(256), .ELEN(32), .NREGS(16), .NRD(3)) bus_b ();

  v_regfile_mp #(.VLEN(512), .ELEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1))
    dut_a (.clk(clk), .rst_n(rst_a_n), .bus(bus_a));
  v_regfile_mp #(.VLEN(256), .ELEN(32), .NREGS(16), .NRD(3), .ZERO_REG(1))
    dut_b (.clk(clk), .rst_n(rst_b_n), .bus(bus_b));

  // ---------------- reference model ----------------
  logic [511:0] mem_a [32];
  logic [255:0] mem_b [16];
  int           left_a = 0, left_b = 0;  // busy cycles still to come
  logic         exp_ba, exp_bb;
  logic [1:0]   exp_va;
  logic [2:0]   exp_vb;
  logic [511:0] exp_da [2];
  logic [255:0] exp_db [3];

  function automatic logic [511:0] merge_m(input logic [511:0] old_v,
      input logic [511:0] new_v, input logic [15:0] mask, input int nel);
    logic [511:0] r;
    r = old_v;
    for (int k = 0; k < nel; k++) if (mask[k]) r[k*32 +: 32] = new_v[k*32 +: 32];
    return r;
  endfunction

  function automatic logic [511:0] rand_vec();
    logic [511:0] v;
    for (int k = 0; k < 16; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Predict the outputs of the coming edge from the driven inputs, then step.
  task automatic tick_a();
    logic         busy_now, wacc;
    logic [511:0] merged;
    logic [4:0]   a;
    busy_now = (left_a > 0);
    wacc = rst_a_n && !busy_now && !bus_a.clr_i && bus_a.w_ena_i && (bus_a.w_addr_i != 5'd0);
    merged = merge_m(mem_a[bus_a.w_addr_i], bus_a.w_data_i, bus_a.w_mask_i, 16);
    for (int p = 0; p < 2; p++) begin
      a = bus_a.r_addr_i[p*5 +: 5];
      exp_va[p] = rst_a_n && !busy_now && bus_a.r_ena_i[p];
      exp_da[p] = '0;
      if (exp_va[p] && a != 5'd0) exp_da[p] = (wacc && a == bus_a.w_addr_i) ? merged : mem_a[a];
    end
    if (wacc) mem_a[bus_a.w_addr_i] = merged;
    if (!rst_a_n || (!busy_now && bus_a.clr_i)) begin
      left_a = 32;
      for (int i = 0; i < 32; i++) mem_a[i] = '0;
    end else if (busy_now) begin
      left_a--;
    end
    exp_ba = (left_a > 0);
    @(posedge clk);
    #1;
  endtask

  task automatic tick_b();
    logic         busy_now, wacc;
    logic [255:0] merged;
    logic [3:0]   a;
    busy_now = (left_b > 0);
    wacc = rst_b_n && !busy_now && !bus_b.clr_i && bus_b.w_ena_i && (bus_b.w_addr_i != 4'd0);
    merged = 256'(merge_m(512'(mem_b[bus_b.w_addr_i]), 512'(bus_b.w_data_i), 16'(bus_b.w_mask_i), 8));
    for (int p = 0; p < 3; p++) begin
      a = bus_b.r_addr_i[p*4 +: 4];
      exp_vb[p] = rst_b_n && !busy_now && bus_b.r_ena_i[p];
      exp_db[p] = '0;
      if (exp_vb[p] && a != 4'd0) exp_db[p] = (wacc && a == bus_b.w_addr_i) ? merged : mem_b[a];
    end
    if (wacc) mem_b[bus_b.w_addr_i] = merged;
    if (!rst_b_n || (!busy_now && bus_b.clr_i)) begin
      left_b = 16;
      for (int i = 0; i < 16; i++) mem_b[i] = '0;
    end else if (busy_now) begin
      left_b--;
    end
    exp_bb = (left_b > 0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- drivers ----------------
  task automatic idle_a();
    bus_a.clr_i = 0; bus_a.w_ena_i = 0; bus_a.w_addr_i = '0; bus_a.w_mask_i = '0;
    bus_a.w_data_i = '0; bus_a.r_ena_i = '0; bus_a.r_addr_i = '0;
  endtask

  task automatic idle_b();
    bus_b.clr_i = 0; bus_b.w_ena_i = 0; bus_b.w_addr_i = '0; bus_b.w_mask_i = '0;
    bus_b.w_data_i = '0; bus_b.r_ena_i = '0; bus_b.r_addr_i = '0;
  endtask

  task automatic write_a(input logic [4:0] addr, input logic [15:0] mask, input logic [511:0] data);
    bus_a.w_ena_i = 1; bus_a.w_addr_i = addr; bus_a.w_mask_i = mask; bus_a.w_data_i = data;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int busy_seen;
    rst_a_n = 0; idle_a(); bus_a.r_ena_i = 2'b11;
    for (int c = 0; c < 3; c++) begin
      bus_a.r_addr_i = 10'($urandom);
      tick_a();
      vecs++; if (bus_a.busy_o !== exp_ba) begin errs++; $display("FAIL reset busy got %b want %b", bus_a.busy_o, exp_ba); end
      vecs++; if (bus_a.r_valid_o !== 2'b00 || bus_a.r_data_o !== '0) begin errs++; $display("FAIL reset outputs valid %b data %h want 0", bus_a.r_valid_o, bus_a.r_data_o[511:0]); end
    end
    busy_seen = (bus_a.busy_o === 1'b1) ? 1 : 0;
    rst_a_n = 1;
    for (int c = 0; c < 33; c++) begin
      bus_a.r_addr_i = 10'($urandom);
      tick_a();
      if (bus_a.busy_o === 1'b1) busy_seen++;
      vecs++; if (bus_a.busy_o !== exp_ba) begin errs++; $display("FAIL clear_run busy got %b want %b", bus_a.busy_o, exp_ba); end
      for (int p = 0; p < 2; p++) begin
        vecs++; if (bus_a.r_valid_o[p] !== exp_va[p] || bus_a.r_data_o[p*512 +: 512] !== exp_da[p]) begin errs++; $display("FAIL clear_run port%0d valid %b want %b data %h want %h", p, bus_a.r_valid_o[p], exp_va[p], bus_a.r_data_o[p*512 +: 512], exp_da[p]); end
      end
    end
    vecs++; if (busy_seen != 32) begin errs++; $display("FAIL busy_len got %0d want 32", busy_seen); end
    for (int r = 1; r < 32; r++) begin
      bus_a.r_addr_i = {5'(32 - r), 5'(r)};
      tick_a();
      vecs++; if (bus_a.r_valid_o !== 2'b11 || bus_a.r_data_o !== '0) begin errs++; $display("FAIL zeroed_reg%0d valid %b data %h want 11 and 0", r, bus_a.r_valid_o, bus_a.r_data_o[511:0]); end
    end
    idle_a();
  endtask

  task automatic test_masked_write();
    write_a(5'd5, 16'hFFFF, {16{32'hA5A5A5A5}}); tick_a();
    write_a(5'd5, 16'h0003, {16{32'h11111111}}); tick_a();
    idle_a(); bus_a.r_ena_i = 2'b11; bus_a.r_addr_i = {5'd5, 5'd5};
    tick_a();
    for (int p = 0; p < 2; p++) begin
      vecs++; if (bus_a.r_valid_o[p] !== exp_va[p] || bus_a.r_data_o[p*512 +: 512] !== exp_da[p]) begin errs++; $display("FAIL masked_write port%0d valid %b data %h want %h", p, bus_a.r_valid_o[p], bus_a.r_data_o[p*512 +: 512], exp_da[p]); end
    end
    vecs++; if (bus_a.r_data_o[31:0] !== 32'h11111111 || bus_a.r_data_o[63:32] !== 32'h11111111) begin errs++; $display("FAIL masked_elem01 got %h want 1111111111111111", bus_a.r_data_o[63:0]); end
    vecs++; if (bus_a.r_data_o[95:64] !== 32'hA5A5A5A5 || bus_a.r_data_o[511:480] !== 32'hA5A5A5A5) begin errs++; $display("FAIL masked_elem2_15 got %h %h want a5a5a5a5", bus_a.r_data_o[95:64], bus_a.r_data_o[511:480]); end
    idle_a();
  endtask

  task automatic test_bypass();
    logic [511:0] prior;
    prior = rand_vec();
    write_a(5'd7, 16'hFFFF, prior); tick_a();
    write_a(5'd7, 16'h8000, {32'hDEADBEEF, 480'd0});
    bus_a.r_ena_i = 2'b01; bus_a.r_addr_i = {5'd0, 5'd7};
    tick_a();
    vecs++; if (bus_a.r_valid_o !== exp_va || bus_a.r_data_o[511:0] !== exp_da[0]) begin errs++; $display("FAIL bypass valid %b data %h want %h", bus_a.r_valid_o, bus_a.r_data_o[511:0], exp_da[0]); end
    vecs++; if (bus_a.r_data_o[511:480] !== 32'hDEADBEEF || bus_a.r_data_o[479:0] !== prior[479:0]) begin errs++; $display("FAIL bypass_elems got %h want %h", bus_a.r_data_o[511:0], {32'hDEADBEEF, prior[479:0]}); end
    vecs++; if (bus_a.r_valid_o[1] !== 1'b0 || bus_a.r_data_o[1023:512] !== '0) begin errs++; $display("FAIL bypass_idle_port valid %b data %h want 0", bus_a.r_valid_o[1], bus_a.r_data_o[1023:512]); end
    idle_a();
  endtask

  task automatic test_zero_reg();
    write_a(5'd0, 16'hFFFF, {16{32'hFFFFFFFF}}); tick_a();
    write_a(5'd0, 16'hFFFF, {16{32'hFFFFFFFF}});
    bus_a.r_ena_i = 2'b11; bus_a.r_addr_i = 10'd0;
    for (int c = 0; c < 2; c++) begin
      tick_a();
      idle_a(); bus_a.r_ena_i = 2'b11;
      vecs++; if (bus_a.r_valid_o !== 2'b11 || bus_a.r_data_o !== '0) begin errs++; $display("FAIL zero_reg valid %b data %h want 11 and 0", bus_a.r_valid_o, bus_a.r_data_o[511:0]); end
      vecs++; if (bus_a.r_valid_o !== exp_va) begin errs++; $display("FAIL zero_reg_model valid %b want %b", bus_a.r_valid_o, exp_va); end
    end
    idle_a();
  endtask

  task automatic test_clear();
    int busy_seen;
    write_a(5'd3, 16'hFFFF, {16{32'h12345678}}); tick_a();
    write_a(5'd4, 16'hFFFF, rand_vec()); bus_a.clr_i = 1;
    tick_a();
    busy_seen = (bus_a.busy_o === 1'b1) ? 1 : 0;
    idle_a(); bus_a.r_ena_i = 2'b11; bus_a.r_addr_i = {5'd4, 5'd3};
    for (int c = 0; c < 32; c++) begin
      tick_a();
      if (bus_a.busy_o === 1'b1) busy_seen++;
      vecs++; if (bus_a.busy_o !== exp_ba) begin errs++; $display("FAIL clr_busy got %b want %b", bus_a.busy_o, exp_ba); end
      vecs++; if (bus_a.r_valid_o !== exp_va || bus_a.r_data_o !== '0) begin errs++; $display("FAIL clr_reads valid %b want %b data %h want 0", bus_a.r_valid_o, exp_va, bus_a.r_data_o[511:0]); end
    end
    vecs++; if (busy_seen != 32) begin errs++; $display("FAIL clr_busy_len got %0d want 32", busy_seen); end
    tick_a();
    vecs++; if (bus_a.r_valid_o !== 2'b11 || bus_a.r_data_o !== '0) begin errs++; $display("FAIL clr_after valid %b data %h want 11 and 0", bus_a.r_valid_o, bus_a.r_data_o[1023:512]); end
    idle_a();
  endtask

  task automatic test_reset_mid_clear();
    int busy_seen;
    bus_a.clr_i = 1; tick_a(); idle_a();
    for (int c = 0; c < 10; c++) tick_a();
    rst_a_n = 0; tick_a(); rst_a_n = 1;
    busy_seen = (bus_a.busy_o === 1'b1) ? 1 : 0;
    bus_a.r_ena_i = 2'b10; bus_a.r_addr_i = {5'd9, 5'd0};
    for (int c = 0; c < 34; c++) begin
      tick_a();
      if (bus_a.busy_o === 1'b1) busy_seen++;
      vecs++; if (bus_a.busy_o !== exp_ba) begin errs++; $display("FAIL rst_mid busy got %b want %b", bus_a.busy_o, exp_ba); end
      vecs++; if (bus_a.r_valid_o !== exp_va || bus_a.r_data_o[1023:512] !== exp_da[1]) begin errs++; $display("FAIL rst_mid valid %b want %b data %h want %h", bus_a.r_valid_o, exp_va, bus_a.r_data_o[1023:512], exp_da[1]); end
    end
    vecs++; if (busy_seen != 32) begin errs++; $display("FAIL rst_mid_len got %0d want 32", busy_seen); end
    idle_a();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      bus_a.clr_i    = ($urandom_range(0, 99) == 0);
      bus_a.w_ena_i  = 1'($urandom_range(0, 1));
      bus_a.w_addr_i = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      bus_a.w_mask_i = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      bus_a.w_data_i = rand_vec();
      bus_a.r_ena_i  = 2'($urandom);
      for (int p = 0; p < 2; p++)
        bus_a.r_addr_i[p*5 +: 5] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      tick_a();
      vecs++; if (bus_a.busy_o !== exp_ba) begin errs++; $display("FAIL random busy cyc %0d got %b want %b", c, bus_a.busy_o, exp_ba); end
      for (int p = 0; p < 2; p++) begin
        vecs++; if (bus_a.r_valid_o[p] !== exp_va[p] || bus_a.r_data_o[p*512 +: 512] !== exp_da[p]) begin errs++; $display("FAIL random cyc %0d port%0d valid %b want %b data %h want %h", c, p, bus_a.r_valid_o[p], exp_va[p], bus_a.r_data_o[p*512 +: 512], exp_da[p]); end
      end
    end
    idle_a();
  endtask

  task automatic test_small_config();
    int busy_seen;
    rst_b_n = 0; idle_b(); bus_b.r_ena_i = 3'b111;
    tick_b(); tick_b();
    vecs++; if (bus_b.busy_o !== 1'b1 || bus_b.r_valid_o !== 3'b000 || bus_b.r_data_o !== '0) begin errs++; $display("FAIL b_reset busy %b valid %b", bus_b.busy_o, bus_b.r_valid_o); end
    busy_seen = (bus_b.busy_o === 1'b1) ? 1 : 0;
    rst_b_n = 1;
    for (int c = 0; c < 120; c++) begin
      if (c >= 20) begin
        bus_b.w_ena_i  = 1'($urandom_range(0, 1));
        bus_b.w_addr_i = 4'($urandom_range(0, 5));
        bus_b.w_mask_i = 8'($urandom);
        bus_b.w_data_i = 256'(rand_vec());
        bus_b.clr_i    = (c == 80);
      end
      bus_b.r_ena_i  = 3'($urandom);
      bus_b.r_addr_i = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 5))};
      tick_b();
      if (c < 20 && bus_b.busy_o === 1'b1) busy_seen++;
      vecs++; if (bus_b.busy_o !== exp_bb) begin errs++; $display("FAIL b_busy cyc %0d got %b want %b", c, bus_b.busy_o, exp_bb); end
      for (int p = 0; p < 3; p++) begin
        vecs++; if (bus_b.r_valid_o[p] !== exp_vb[p] || bus_b.r_data_o[p*256 +: 256] !== exp_db[p]) begin errs++; $display("FAIL b_read cyc %0d port%0d valid %b want %b data %h want %h", c, p, bus_b.r_valid_o[p], exp_vb[p], bus_b.r_data_o[p*256 +: 256], exp_db[p]); end
      end
    end
    vecs++; if (busy_seen != 16) begin errs++; $display("FAIL b_busy_len got %0d want 16", busy_seen); end
    idle_b();
  endtask

  initial begin
    rst_a_n = 0; rst_b_n = 0;
    idle_a(); idle_b();
    test_reset();
    test_masked_write();
    test_bypass();
    test_zero_reg();
    test_clear();
    test_reset_mid_clear();
    test_random();
    test_small_config();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached after %0d vectors", vecs);
    $fatal(1, "watchdog");
  end

endmodule
